// File: rtl/io_hex_display_pkg.sv
// Shared definitions for the hex/decimal display: converter FSM states,
// digit count and the active-low seven-segment decoder.
package io_hex_display_pkg;

    localparam int NDIG = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } conv_state_t;

    // Segment order is {g,f,e,d,c,b,a}, a lit segment is 0
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'd0:    seg_decode = SEG_0;
            4'd1:    seg_decode = SEG_1;
            4'd2:    seg_decode = SEG_2;
            4'd3:    seg_decode = SEG_3;
            4'd4:    seg_decode = SEG_4;
            4'd5:    seg_decode = SEG_5;
            4'd6:    seg_decode = SEG_6;
            4'd7:    seg_decode = SEG_7;
            4'd8:    seg_decode = SEG_8;
            4'd9:    seg_decode = SEG_9;
            default: seg_decode = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/io_hex_display_if.sv
// Port bundle between a CPU output port and its display instance.
interface io_hex_display_if;
    logic [31:0] value;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        busy;
    logic        ovf;

    modport master (output value, input an, seg, busy, ovf);
    modport slave  (input value, output an, seg, busy, ovf);
endinterface

// File: rtl/io_hex_display_bin2bcd_seq.sv
// Sequential double-dabble converter: 32-bit binary to 10 BCD digits,
// one bit per cycle, 32 CONV cycles plus one DONE cycle.
module bin2bcd_seq
    import io_hex_display_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] bin,
    output logic        busy,
    output logic        done,
    output logic [39:0] bcd
);

    conv_state_t state;
    logic [31:0] shreg;
    logic [39:0] bcd_work;
    logic [39:0] bcd_adj;
    logic [4:0]  bit_cnt;

    // Pre-shift correction so every nibble stays a valid decimal digit after doubling
    always_comb begin
        bcd_adj = bcd_work;
        for (int i = 0; i < 10; i++) begin
            if (bcd_work[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_work[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            shreg    <= '0;
            bcd_work <= '0;
            bit_cnt  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg    <= bin;
                        bcd_work <= '0;
                        bit_cnt  <= '0;
                        busy     <= 1'b1;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    {bcd_work, shreg} <= {bcd_adj, shreg} << 1;
                    bit_cnt <= bit_cnt + 5'd1;
                    if (bit_cnt == 5'd31) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bcd = bcd_work;

endmodule

// File: rtl/io_hex_display.sv
// Decimal display for one CPU output port: change detect, BCD conversion,
// digit scan and decode. Define DISP_LZB_EN for leading-zero blanking.
module io_hex_display
    import io_hex_display_pkg::*;
#(
    parameter int SCAN_DIV = 50000
)(
    input  logic             clock,
    input  logic             reset,
    io_hex_display_if.slave  bus
);

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);

    logic [31:0]      last_val;
    logic [31:0]      bcd_disp;
    logic             ovf_r;
    logic             start;
    logic             conv_busy;
    logic             conv_done;
    logic [39:0]      conv_bcd;
    logic [CNT_W-1:0] scan_cnt;
    logic [2:0]       digit_idx;
    logic [3:0]       cur_nib;
    logic             blank;
    logic [7:0]       an_r;
    logic [6:0]       seg_r;

    // Changes arriving while converting are picked up once the FSM is idle again
    assign start = !conv_busy && (bus.value != last_val);

    bin2bcd_seq u_conv (
        .clock (clock),
        .reset (reset),
        .start (start),
        .bin   (bus.value),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            last_val <= '0;
            bcd_disp <= '0;
            ovf_r    <= 1'b0;
        end else begin
            if (start)
                last_val <= bus.value;
            if (conv_done) begin
                bcd_disp <= conv_bcd[31:0];
                ovf_r    <= |conv_bcd[39:32];
            end
        end
    end

    assign cur_nib = bcd_disp[{digit_idx, 2'b00} +: 4];

`ifdef DISP_LZB_EN
    logic [2:0] msd;

    // Digit 0 is never blanked, so an all-zero value still shows "0"
    always_comb begin
        msd = '0;
        for (int i = 1; i < NDIG; i++) begin
            if (bcd_disp[4*i +: 4] != 4'd0)
                msd = 3'(i);
        end
    end

    assign blank = !ovf_r && (digit_idx > msd);
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
            an_r      <= 8'hFE;
            seg_r     <= SEG_0;
        end else begin
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt  <= '0;
                digit_idx <= digit_idx + 3'd1;
            end else begin
                scan_cnt <= scan_cnt + CNT_W'(1);
            end
            an_r  <= ~(8'd1 << digit_idx);
            seg_r <= blank ? SEG_BLANK : seg_decode(cur_nib);
        end
    end

    assign bus.an   = an_r;
    assign bus.seg  = seg_r;
    assign bus.busy = conv_busy;
    assign bus.ovf  = ovf_r;

endmodule

// File: tb/tb_io_hex_display.sv
// Self-checking bench for io_hex_display with a short scan period; expected
// displays go through a scoreboard queue and are checked per scanned digit.
module tb_io_hex_display;

    localparam int SCAN_DIV = 4;
`ifdef DISP_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;

    io_hex_display_if bus();

    io_hex_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] value;
        logic [31:0] exp_bcd;
        logic        exp_ovf;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] bcd;
        logic        ovf;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[7];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        case (n)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [6:0] exp_digit(input logic [31:0] bcd, input logic ovf, input int d);
        int msd;
        msd = 0;
        for (int i = 1; i < 8; i++)
            if (bcd[4*i +: 4] != 4'd0) msd = i;
        if (LZB && !ovf && d > msd) return 7'h7F;
        return ref_seg(bcd[4*d +: 4]);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [31:0] v, input logic [31:0] bcd,
                                  input logic ovf, input string name, input bit expect_conv);
        @(negedge clock);
        bus.value = v;
        if (expect_conv) begin
            exp_t e;
            e.bcd  = bcd;
            e.ovf  = ovf;
            e.name = name;
            sb_q.push_back(e);
        end
    endtask

    task automatic check_output(input bit check_busy);
        exp_t e;
        int   t;
        int   busy_cycles;
        int   d;
        int   nseen;
        bit   seen[8];
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("[TB] FAIL scoreboard: no expected entry queued");
            return;
        end
        e = sb_q.pop_front();
        t = 0;
        while (!bus.busy && t < 200) begin
            @(negedge clock);
            t++;
        end
        busy_cycles = 0;
        while (bus.busy && t < 400) begin
            busy_cycles++;
            @(negedge clock);
            t++;
        end
        if (busy_cycles == 0 || bus.busy) begin
            n_cmp++;
            n_err++;
            $display("[TB] FAIL %s timeout: busy=%0b after %0d cycles", e.name, bus.busy, t);
            return;
        end
        if (check_busy)
            check($sformatf("%s busy_len", e.name), busy_cycles, 33);
        check($sformatf("%s ovf", e.name), {31'd0, bus.ovf}, {31'd0, e.ovf});
        @(negedge clock);
        for (int i = 0; i < 8; i++) seen[i] = 1'b0;
        nseen = 0;
        for (int s = 0; s < 32; s++) begin
            d = -1;
            for (int i = 0; i < 8; i++)
                if (bus.an == 8'(~(8'd1 << i))) d = i;
            if (d >= 0 && !seen[d]) begin
                seen[d] = 1'b1;
                nseen++;
                check($sformatf("%s dig%0d", e.name, d), {25'd0, bus.seg},
                      {25'd0, exp_digit(e.bcd, e.ovf, d)});
            end
            @(negedge clock);
        end
        check($sformatf("%s scan_cover", e.name), nseen, 8);
    endtask

    initial begin
        int quiet_busy;
        int exp_idx;

        vecs[0] = '{32'd12345678,  32'h12345678, 1'b0, "v12345678"};
        vecs[1] = '{32'hFFFFFFFF,  32'h94967295, 1'b1, "vFFFFFFFF"};
        vecs[2] = '{32'd5,         32'h00000005, 1'b0, "v5"};
        vecs[3] = '{32'd99999999,  32'h99999999, 1'b0, "v99999999"};
        vecs[4] = '{32'd100000000, 32'h00000000, 1'b1, "v100000000"};
        vecs[5] = '{32'd0,         32'h00000000, 1'b0, "v0"};
        vecs[6] = '{32'd305,       32'h00000305, 1'b0, "v305"};

        bus.value = 32'd0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        check("reset an",   {24'd0, bus.an},   32'hFE);
        check("reset seg",  {25'd0, bus.seg},  32'h40);
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset ovf",  {31'd0, bus.ovf},  32'd0);

        // an walk with value 0: each digit lit SCAN_DIV cycles, one-cycle output lag
        for (int k = 0; k <= 40; k++) begin
            exp_idx = (k == 0) ? 0 : ((k - 1) / SCAN_DIV) % 8;
            check($sformatf("scan k%0d", k), {24'd0, bus.an}, {24'd0, 8'(~(8'd1 << exp_idx))});
            @(negedge clock);
        end

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].value, vecs[i].exp_bcd, vecs[i].exp_ovf, vecs[i].name, 1'b1);
            check_output(1'b1);
        end

        // Same value written again must not restart the converter
        apply_stimulus(32'd305, 32'h0, 1'b0, "same", 1'b0);
        quiet_busy = 0;
        repeat (40) begin
            @(negedge clock);
            if (bus.busy) quiet_busy++;
        end
        check("same_value busy", quiet_busy, 0);

        // Change 100 -> 200 ten cycles into the first conversion
        apply_stimulus(32'd100, 32'h00000100, 1'b0, "mid100", 1'b1);
        for (int t = 0; t < 50 && !bus.busy; t++) @(negedge clock);
        repeat (10) @(negedge clock);
        apply_stimulus(32'd200, 32'h00000200, 1'b0, "mid200", 1'b1);
        check_output(1'b0);
        check_output(1'b0);

        // Reset while converting, with ovf set beforehand
        apply_stimulus(32'hFFFFFFFF, 32'h94967295, 1'b1, "pre_rst", 1'b1);
        check_output(1'b1);
        apply_stimulus(32'd12345678, 32'h0, 1'b0, "abort", 1'b0);
        for (int t = 0; t < 50 && !bus.busy; t++) @(negedge clock);
        repeat (5) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("midrst busy", {31'd0, bus.busy}, 32'd0);
        check("midrst ovf",  {31'd0, bus.ovf},  32'd0);
        check("midrst an",   {24'd0, bus.an},   32'hFE);
        check("midrst seg",  {25'd0, bus.seg},  32'h40);
        reset = 1'b0;
        sb_q.push_back('{32'h12345678, 1'b0, "post_rst"});
        check_output(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
